// File: rtl/dma_pkg.sv
// Shared types and limits for the ROM-to-RAM copy sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_pkg;

  // Controller states: idle, issuing ROM reads, waiting for in-flight data, completion pulse
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } dma_state_t;

  // Deepest ROM read latency the tracking pipeline is built for
  localparam int ROM_LATENCY_MAX = 4;

endpackage

// File: rtl/dma_rd_pipe.sv
// Tracks outstanding ROM reads as (valid, destination address) pairs.
// Latency: STAGES cycles from push to pop; one entry per cycle.
// Backpressure: none; flush discards every entry at the next edge.
module dma_rd_pipe #(
  parameter int STAGES = 1,
  parameter int AW     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push_vld,
  input  logic [AW-1:0] i_push_addr,
  output logic          o_pop_vld,
  output logic [AW-1:0] o_pop_addr,
  output logic          o_inflight
);

  logic [STAGES-1:0]         r_vld;
  logic [STAGES-1:0][AW-1:0] r_addr;

  // Address stages carry zero when empty so the pop address is quiet between writes
  logic [AW-1:0] w_push_addr;
  assign w_push_addr = i_push_vld ? i_push_addr : '0;

  if (STAGES == 1) begin : g_single
    // Single stage: entry lands directly in the output slot
    always_ff @(posedge clk) begin
      if (reset || i_flush) begin
        r_vld  <= '0;
        r_addr <= '0;
      end else begin
        r_vld  <= i_push_vld;
        r_addr <= w_push_addr;
      end
    end
    // Nothing can be behind the output slot
    assign o_inflight = 1'b0;
  end else begin : g_multi
    // Shift toward the output slot (highest index) every cycle
    always_ff @(posedge clk) begin
      if (reset || i_flush) begin
        r_vld  <= '0;
        r_addr <= '0;
      end else begin
        r_vld  <= {r_vld[STAGES-2:0], i_push_vld};
        r_addr <= {r_addr[STAGES-2:0], w_push_addr};
      end
    end
    // Entries still upstream of the output slot
    assign o_inflight = |r_vld[STAGES-2:0];
  end

  assign o_pop_vld  = r_vld[STAGES-1];
  assign o_pop_addr = r_addr[STAGES-1];

endmodule

// File: rtl/dma_copy_ctrl.sv
// Copies a block of words from a synchronous ROM read port to a RAM write port.
// Latency: first read one cycle after start, first write ROM_LATENCY later, done after the last write.
// Backpressure: none; one command at a time, start ignored unless idle, abort stops the copy.
module dma_copy_ctrl
  import dma_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int DEPTH       = 8,
  parameter  int ROM_LATENCY = 1,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  rom_rd_en,
  output logic [ADDR_WIDTH-1:0] rom_rd_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data
);

  // Keep the tracking pipe inside the supported latency range
  localparam int LP_LAT = (ROM_LATENCY < 1) ? 1 :
                          (ROM_LATENCY > ROM_LATENCY_MAX) ? ROM_LATENCY_MAX : ROM_LATENCY;
  localparam logic [ADDR_WIDTH+1:0] LP_DEPTH = (ADDR_WIDTH+2)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LP_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  dma_state_t r_state;
  dma_state_t w_next;

  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_err;

  logic [ADDR_WIDTH+1:0] w_src_end;
  logic [ADDR_WIDTH+1:0] w_dst_end;
  logic                  w_zero;
  logic                  w_fault;
  logic                  w_last;
  logic                  w_rd_en;
  logic                  w_flush;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_push_addr;
  logic                  w_pop_vld;
  logic [ADDR_WIDTH-1:0] w_pop_addr;
  logic                  w_inflight;

  // End addresses are computed two bits wider so src+length cannot wrap
  assign w_src_end   = {2'b00, src_addr} + {1'b0, length};
  assign w_dst_end   = {2'b00, dst_addr} + {1'b0, length};
  assign w_zero      = (length == '0);
  assign w_fault     = (w_src_end > LP_DEPTH) || (w_dst_end > LP_DEPTH);
  assign w_last      = ((r_cnt + LP_ONE) == r_len);
  assign w_rd_addr   = r_src + r_cnt[ADDR_WIDTH-1:0];
  assign w_push_addr = r_dst + r_cnt[ADDR_WIDTH-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: zero length and range faults skip straight to the completion pulse
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (w_zero || w_fault) ? FINISH : READ;
        end
      end
      READ: begin
        if (abort) begin
          w_next = FINISH;
        end else if (w_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (abort || !w_inflight) begin
          w_next = FINISH;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Command latch, read index and error flag; a start while busy leaves the command untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_src <= src_addr;
            r_dst <= dst_addr;
            r_len <= length;
            r_cnt <= '0;
            r_err <= w_fault && !w_zero;
          end
        end
        READ: begin
          r_cnt <= r_cnt + LP_ONE;
          if (abort) begin
            r_err <= 1'b1;
          end
        end
        DRAIN: begin
          if (abort) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state; abort flushes the pipe so nothing is written after it
  always_comb begin
    w_rd_en = 1'b0;
    w_flush = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    case (r_state)
      READ: begin
        w_rd_en = 1'b1;
        w_flush = abort;
        busy    = 1'b1;
      end
      DRAIN: begin
        w_flush = abort;
        busy    = 1'b1;
      end
      FINISH: begin
        done  = 1'b1;
        error = r_err;
      end
      default: begin
      end
    endcase
  end

  assign rom_rd_en   = w_rd_en;
  assign rom_rd_addr = w_rd_en ? w_rd_addr : '0;
  assign ram_wr_en   = w_pop_vld;
  assign ram_wr_addr = w_pop_vld ? w_pop_addr : '0;
  assign ram_wr_data = rom_rd_data;

  dma_rd_pipe #(
    .STAGES (LP_LAT),
    .AW     (ADDR_WIDTH)
  ) u_rd_pipe (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (w_flush),
    .i_push_vld  (w_rd_en),
    .i_push_addr (w_push_addr),
    .o_pop_vld   (w_pop_vld),
    .o_pop_addr  (w_pop_addr),
    .o_inflight  (w_inflight)
  );

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Bench for dma_copy_ctrl: two instances (ROM latency 1 and 3) share one command stream.
// Each cycle both are compared with a closed-form timing model; RAM images are checked after every command.
module tb_dma_copy_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
  } obs_t;

  typedef struct {
    int src;
    int dst;
    int len;
    int ab;
    int done_a;
    int done_b;
    int err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] src_addr;
  logic [2:0] dst_addr;
  logic [3:0] length;
  logic       ram_clr;

  logic       a_busy, a_done, a_err, a_rd_en, a_wr_en;
  logic [2:0] a_rd_addr, a_wr_addr;
  logic [7:0] a_rd_data, a_wr_data;
  logic       b_busy, b_done, b_err, b_rd_en, b_wr_en;
  logic [2:0] b_rd_addr, b_wr_addr;
  logic [7:0] b_rd_data, b_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram_a [8];
  logic [7:0] ram_b [8];
  logic [7:0] mram_a [8];
  logic [7:0] mram_b [8];
  logic [7:0] rom_q_a;
  logic [7:0] rom_q_b [3];

  always #5 clk = ~clk;

  dma_copy_ctrl #(.DATA_WIDTH(8), .DEPTH(8), .ROM_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .abort(abort), .busy(a_busy), .done(a_done), .error(a_err),
    .rom_rd_en(a_rd_en), .rom_rd_addr(a_rd_addr), .rom_rd_data(a_rd_data),
    .ram_wr_en(a_wr_en), .ram_wr_addr(a_wr_addr), .ram_wr_data(a_wr_data)
  );

  dma_copy_ctrl #(.DATA_WIDTH(8), .DEPTH(8), .ROM_LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .abort(abort), .busy(b_busy), .done(b_done), .error(b_err),
    .rom_rd_en(b_rd_en), .rom_rd_addr(b_rd_addr), .rom_rd_data(b_rd_data),
    .ram_wr_en(b_wr_en), .ram_wr_addr(b_wr_addr), .ram_wr_data(b_wr_data)
  );

  function automatic logic [7:0] rom_word(input int a);
    return 8'(3 * a);
  endfunction

  // ROM models with latency 1 and 3
  always @(posedge clk) begin
    rom_q_a    <= rom_word(int'(a_rd_addr));
    rom_q_b[0] <= rom_word(int'(b_rd_addr));
    rom_q_b[1] <= rom_q_b[0];
    rom_q_b[2] <= rom_q_b[1];
  end
  assign a_rd_data = rom_q_a;
  assign b_rd_data = rom_q_b[2];

  // RAM models
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 8; i++) begin
        ram_a[i] <= 8'hAA;
        ram_b[i] <= 8'hAA;
      end
    end else begin
      if (a_wr_en) ram_a[a_wr_addr] <= a_wr_data;
      if (b_wr_en) ram_b[b_wr_addr] <= b_wr_data;
    end
  end

  obs_t act_a, act_b, raw_a, raw_b;
  always_comb begin
    act_a         = '0;
    act_a.busy    = a_busy;
    act_a.done    = a_done;
    act_a.err     = a_err;
    act_a.rd_en   = a_rd_en;
    act_a.rd_addr = a_rd_en ? a_rd_addr : 3'd0;
    act_a.wr_en   = a_wr_en;
    act_a.wr_addr = a_wr_en ? a_wr_addr : 3'd0;
    act_a.wr_data = a_wr_en ? a_wr_data : 8'd0;
    act_b         = '0;
    act_b.busy    = b_busy;
    act_b.done    = b_done;
    act_b.err     = b_err;
    act_b.rd_en   = b_rd_en;
    act_b.rd_addr = b_rd_en ? b_rd_addr : 3'd0;
    act_b.wr_en   = b_wr_en;
    act_b.wr_addr = b_wr_en ? b_wr_addr : 3'd0;
    act_b.wr_data = b_wr_en ? b_wr_data : 8'd0;
    raw_a = '{a_busy, a_done, a_err, a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, 8'd0};
    raw_b = '{b_busy, b_done, b_err, b_rd_en, b_rd_addr, b_wr_en, b_wr_addr, 8'd0};
  end

  function automatic string fmt(input obs_t o);
    return $sformatf("busy=%0b done=%0b err=%0b rd_en=%0b rd_addr=%0d wr_en=%0b wr_addr=%0d wr_data=%0d",
                     o.busy, o.done, o.err, o.rd_en, o.rd_addr, o.wr_en, o.wr_addr, o.wr_data);
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_fault(input int src, input int dst, input int len);
    return (src + len > 8) || (dst + len > 8);
  endfunction

  // Expected outputs in cycle k (start presented in cycle 0); ab = cycle abort is held, -1 for none
  function automatic obs_t model(input int lat, input int k, input int src, input int dst,
                                 input int len, input int ab);
    obs_t e;
    int   endc;
    int   lastb;
    int   i;
    bit   aborted;
    e = '0;
    if (k < 1) return e;
    if (len == 0 || is_fault(src, dst, len)) begin
      if (k == 1) begin
        e.done = 1'b1;
        e.err  = is_fault(src, dst, len);
      end
      return e;
    end
    endc    = len + lat;
    aborted = (ab >= 1) && (ab <= endc);
    lastb   = aborted ? ab : endc;
    e.busy  = (k <= lastb);
    if (k == lastb + 1) begin
      e.done = 1'b1;
      e.err  = aborted;
    end
    if (k <= len && k <= lastb) begin
      e.rd_en   = 1'b1;
      e.rd_addr = 3'(src + k - 1);
    end
    i = k - 1 - lat;
    if (i >= 0 && i < len && k <= lastb) begin
      e.wr_en   = 1'b1;
      e.wr_addr = 3'(dst + i);
      e.wr_data = rom_word(src + i);
    end
    return e;
  endfunction

  function automatic int done_cyc(input int lat, input int src, input int dst,
                                  input int len, input int ab);
    int endc;
    if (len == 0 || is_fault(src, dst, len)) return 1;
    endc = len + lat;
    return (ab >= 1 && ab <= endc) ? ab + 1 : endc + 1;
  endfunction

  task automatic check_rams(input string tag);
    for (int i = 0; i < 8; i++) begin
      check_int($sformatf("%s_ram_a[%0d]", tag, i), int'(ram_a[i]), int'(mram_a[i]));
      check_int($sformatf("%s_ram_b[%0d]", tag, i), int'(ram_b[i]), int'(mram_b[i]));
    end
  endtask

  // Called #1 after an edge (start of cycle 0); returns the observed done cycle and error flag per instance
  task automatic run_cmd(input string tag, input int src, input int dst, input int len, input int ab,
                         output int done_a, output int done_b, output int err_a, output int err_b);
    obs_t ea, eb;
    int   dmin;
    bit   normal;
    dmin   = done_cyc(1, src, dst, len, ab);
    if (done_cyc(3, src, dst, len, ab) < dmin) dmin = done_cyc(3, src, dst, len, ab);
    normal = (len != 0) && !is_fault(src, dst, len);
    done_a = -1;
    done_b = -1;
    err_a  = -1;
    err_b  = -1;
    start    = 1'b1;
    src_addr = 3'(src);
    dst_addr = 3'(dst);
    length   = 4'(len);
    abort    = (ab == 0);
    for (int k = 0; k <= len + 6; k++) begin
      @(negedge clk);
      ea = model(1, k, src, dst, len, ab);
      eb = model(3, k, src, dst, len, ab);
      check_obs($sformatf("%s_lat1_cyc%0d", tag, k), act_a, ea);
      check_obs($sformatf("%s_lat3_cyc%0d", tag, k), act_b, eb);
      if (act_a.done && done_a < 0) begin done_a = k; err_a = int'(act_a.err); end
      if (act_b.done && done_b < 0) begin done_b = k; err_b = int'(act_b.err); end
      if (ea.wr_en) mram_a[ea.wr_addr] = ea.wr_data;
      if (eb.wr_en) mram_b[eb.wr_addr] = eb.wr_data;
      @(posedge clk);
      #1;
      // Stray starts land only while both instances are busy or finishing
      start = ((k + 1 == 2) && normal) || (k + 1 == dmin);
      if (start) begin
        src_addr = 3'($urandom_range(0, 7));
        dst_addr = 3'($urandom_range(0, 7));
        length   = 4'($urandom_range(0, 8));
      end
      abort = (k + 1 == ab);
    end
    start = 1'b0;
    abort = 1'b0;
    check_rams(tag);
  endtask

  vec_t vecs [8];

  initial begin
    int da, db, ra, rb;
    obs_t ea, eb;
    vecs[0] = '{src:2, dst:0, len:4, ab:-1, done_a:6,  done_b:8,  err:0};
    vecs[1] = '{src:0, dst:0, len:8, ab:-1, done_a:10, done_b:12, err:0};
    vecs[2] = '{src:0, dst:0, len:0, ab:-1, done_a:1,  done_b:1,  err:0};
    vecs[3] = '{src:6, dst:0, len:3, ab:-1, done_a:1,  done_b:1,  err:1};
    vecs[4] = '{src:0, dst:7, len:2, ab:-1, done_a:1,  done_b:1,  err:1};
    vecs[5] = '{src:1, dst:4, len:3, ab:-1, done_a:5,  done_b:7,  err:0};
    vecs[6] = '{src:0, dst:0, len:6, ab:3,  done_a:4,  done_b:4,  err:1};
    vecs[7] = '{src:3, dst:1, len:4, ab:0,  done_a:6,  done_b:8,  err:0};

    reset    = 1'b1;
    ram_clr  = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    for (int i = 0; i < 8; i++) begin
      mram_a[i] = 8'hAA;
      mram_b[i] = 8'hAA;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_obs("reset_state_lat1", raw_a, '0);
    check_obs("reset_state_lat3", raw_b, '0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    ram_clr = 1'b0;

    // Directed vectors
    for (int t = 0; t < 8; t++) begin
      run_cmd($sformatf("vec%0d", t), vecs[t].src, vecs[t].dst, vecs[t].len, vecs[t].ab, da, db, ra, rb);
      check_int($sformatf("vec%0d_done_cycle_lat1", t), da, vecs[t].done_a);
      check_int($sformatf("vec%0d_done_cycle_lat3", t), db, vecs[t].done_b);
      check_int($sformatf("vec%0d_error_lat1", t), ra, vecs[t].err);
      check_int($sformatf("vec%0d_error_lat3", t), rb, vecs[t].err);
    end

    // Reset during cycle 3 of a six-word copy
    start    = 1'b1;
    src_addr = 3'd0;
    dst_addr = 3'd2;
    length   = 4'd6;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      ea = model(1, k, 0, 2, 6, -1);
      eb = model(3, k, 0, 2, 6, -1);
      check_obs($sformatf("rst_lat1_cyc%0d", k), act_a, ea);
      check_obs($sformatf("rst_lat3_cyc%0d", k), act_b, eb);
      if (ea.wr_en) mram_a[ea.wr_addr] = ea.wr_data;
      if (eb.wr_en) mram_b[eb.wr_addr] = eb.wr_data;
      @(posedge clk);
      #1;
      start = 1'b0;
      reset = (k + 1 == 3);
    end
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      check_obs($sformatf("rst_quiet_lat1_cyc%0d", k), raw_a, '0);
      check_obs($sformatf("rst_quiet_lat3_cyc%0d", k), raw_b, '0);
      @(posedge clk);
      #1;
    end
    check_rams("rst");
    run_cmd("post_rst", 3, 2, 5, -1, da, db, ra, rb);
    check_int("post_rst_done_cycle_lat1", da, 7);
    check_int("post_rst_done_cycle_lat3", db, 9);

    // Randomized commands against the model
    for (int r = 0; r < 40; r++) begin
      int s, d, l, ab;
      s  = int'($urandom_range(0, 7));
      d  = int'($urandom_range(0, 7));
      l  = int'($urandom_range(0, 8));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_cmd($sformatf("rnd%0d", r), s, d, l, ab, da, db, ra, rb);
      check_int($sformatf("rnd%0d_done_cycle_lat1", r), da, done_cyc(1, s, d, l, ab));
      check_int($sformatf("rnd%0d_done_cycle_lat3", r), db, done_cyc(3, s, d, l, ab));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
